// File: rtl/ucode_pkg.sv
// Shared microcode definitions: microinstruction field positions, bus codes
// and the two hardwired fetch words used by the microsequencer.
package ucode_pkg;

    localparam int EO_BAR_BIT  = 15;
    localparam int RT_BIT      = 11;
    localparam int PP_BIT      = 10;
    localparam int HALT_BIT    = 0;

    localparam int BUS_OUT_LSB = 12;
    localparam int BUS_IN_LSB  = 5;

    localparam int PO = 0;
    localparam int MO = 3;
    localparam int AI = 1;
    localparam int II = 2;

    // Built from fields so the encoding stays self-documenting: 16'h8020 and 16'hB440.
    localparam logic [15:0] FETCH_T0 = 16'(1 << EO_BAR_BIT)
                                     | 16'(PO << BUS_OUT_LSB)
                                     | 16'(AI << BUS_IN_LSB);
    localparam logic [15:0] FETCH_T1 = 16'(1 << EO_BAR_BIT)
                                     | 16'(MO << BUS_OUT_LSB)
                                     | 16'(1 << PP_BIT)
                                     | 16'(II << BUS_IN_LSB);

endpackage

// File: rtl/microsequencer_if.sv
// Microsequencer-facing bus: opcode/ROM/ready inputs and the uinstr outputs
// that feed the control decoder.
interface microsequencer_if #(
    parameter int OPCODE_W = 8,
    parameter int T_W      = 3,
    parameter int UINSTR_W = 16
);
    logic [OPCODE_W-1:0]     opcode;
    logic [UINSTR_W-1:0]     rom_data;
    logic                    ready;
    logic [OPCODE_W+T_W-1:0] rom_addr;
    logic [UINSTR_W-1:0]     uinstr;
    logic [T_W-1:0]          tstate;
    logic                    instr_start;
    logic                    halted;

    modport master (
        input  opcode, rom_data, ready,
        output rom_addr, uinstr, tstate, instr_start, halted
    );

    modport slave (
        output opcode, rom_data, ready,
        input  rom_addr, uinstr, tstate, instr_start, halted
    );
endinterface

// File: rtl/microsequencer_tstate_counter.sv
// T-state counter: synchronous clear, advance enable, early restart (RT) and
// natural wrap from the last T-state back to zero.
module tstate_counter #(
    parameter int T_W = 3
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           en,
    input  logic           restart,
    output logic [T_W-1:0] count
);
    logic [T_W-1:0] count_reg;
    logic [T_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (en) begin
            if (restart || count_reg == {T_W{1'b1}}) begin
                count_next = '0;
            end else begin
                count_next = count_reg + T_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/microsequencer.sv
// Microsequencer: T-state sequencing, fetch-word injection and RT decode.
// Optional halt-on-bit-0 behaviour is enabled by defining MICROSEQ_HALT_EN.
module microsequencer
    import ucode_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int T_W      = 3,
    parameter int UINSTR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    microsequencer_if.master bus
);
    logic [T_W-1:0]      tstate;
    logic [UINSTR_W-1:0] uinstr;
    logic                rt;
    logic                rom_phase;
    logic                halted_reg;
    logic                adv_en;

    assign rom_phase = (tstate >= T_W'(2));

    always_comb begin
        uinstr = bus.rom_data;
        if (tstate == T_W'(0)) begin
            uinstr = UINSTR_W'(FETCH_T0);
        end else if (tstate == T_W'(1)) begin
            uinstr = UINSTR_W'(FETCH_T1);
        end
    end

    // RT only counts when EO_bar is high; the bit is shared with another field otherwise.
    assign rt     = uinstr[EO_BAR_BIT] & uinstr[RT_BIT];
    assign adv_en = bus.ready & ~halted_reg;

    tstate_counter #(
        .T_W(T_W)
    ) u_tstate_counter (
        .clk    (clk),
        .srst   (reset),
        .en     (adv_en),
        .restart(rt),
        .count  (tstate)
    );

`ifdef MICROSEQ_HALT_EN
    // The halting edge still advances tstate because adv_en uses the old halted_reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_reg <= 1'b0;
        end else if (bus.ready && rom_phase && uinstr[HALT_BIT]) begin
            halted_reg <= 1'b1;
        end
    end
`else
    logic unused_rom_phase;
    assign unused_rom_phase = rom_phase;
    assign halted_reg       = 1'b0;
`endif

    assign bus.rom_addr    = {bus.opcode, tstate};
    assign bus.uinstr      = uinstr;
    assign bus.tstate      = tstate;
    assign bus.instr_start = (tstate == T_W'(0));
    assign bus.halted      = halted_reg;
endmodule
